// File: rtl/multicycle_mem_responder.sv
// Memory-side responder for the multicycle core: accepts one request, waits LATENCY
// cycles, then completes it against an internal word RAM with a one-cycle ready pulse.
module multicycle_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_mask,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        error,
  output logic        busy
);

  localparam int         DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int         IW    = ADDR_WIDTH - 2;
  localparam logic [3:0] LAT_L = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t          state_r, next_state_s;
  logic [3:0]      count_r;
  logic            write_r, illegal_r;
  logic [IW-1:0]   idx_r;
  logic [31:0]     wdata_r;
  logic [3:0]      mask_r;
  logic            ready_r, error_r, busy_r;
  logic [31:0]     read_data_r;
  logic [31:0]     mem_r [DEPTH];

  logic            accept_s, cur_illegal_s, cur_write_s;
  logic [IW-1:0]   cur_idx_s;

  function automatic logic req_illegal(input logic re, input logic we, input logic [31:0] a);
    return (re & we) | (a[1:0] != 2'b00) | ((a >> ADDR_WIDTH) != 32'd0);
  endfunction

  // With LATENCY=0 the response is formed at the accept edge, so use the live request then.
  assign accept_s      = (state_r == IDLE) & (read_enable | write_enable);
  assign cur_illegal_s = accept_s ? req_illegal(read_enable, write_enable, address) : illegal_r;
  assign cur_write_s   = accept_s ? write_enable : write_r;
  assign cur_idx_s     = accept_s ? address[ADDR_WIDTH-1:2] : idx_r;

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (LAT_L == 4'd0) begin
            next_state_s = RESPOND;
          end else begin
            next_state_s = WAIT;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (count_r <= 4'd1) begin
          next_state_s = RESPOND;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESPOND: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, request latch, counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      count_r     <= 4'd0;
      write_r     <= 1'b0;
      illegal_r   <= 1'b0;
      idx_r       <= '0;
      wdata_r     <= 32'd0;
      mask_r      <= 4'd0;
      ready_r     <= 1'b0;
      error_r     <= 1'b0;
      busy_r      <= 1'b0;
      read_data_r <= 32'd0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      ready_r <= (next_state_s == RESPOND);
      error_r <= (next_state_s == RESPOND) & cur_illegal_s;
      if (accept_s) begin
        write_r   <= write_enable;
        illegal_r <= cur_illegal_s;
        idx_r     <= cur_idx_s;
        wdata_r   <= write_data;
        mask_r    <= byte_mask;
        count_r   <= LAT_L;
      end else if (state_r == WAIT) begin
        count_r <= count_r - 4'd1;
      end
      if ((next_state_s == RESPOND) && !cur_illegal_s && !cur_write_s) begin
        read_data_r <= mem_r[cur_idx_s];
      end
    end
  end

  // Write commit at the end of the RESPOND cycle; RAM survives reset.
  always_ff @(posedge clock) begin
    if ((state_r == RESPOND) && write_r && !illegal_r) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_r[i]) begin
          mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  assign read_data = read_data_r;
  assign ready     = ready_r;
  assign error     = error_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Directed bench for multicycle_mem_responder: a LATENCY=2 and a LATENCY=0 instance.
module tb_multicycle_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        re2 = 1'b0, we2 = 1'b0, re0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr2 = 32'd0, wd2 = 32'd0, addr0 = 32'd0, wd0 = 32'd0;
  logic [3:0]  mask2 = 4'd0, mask0 = 4'd0;
  logic [31:0] rd2, rd0;
  logic        ready2, error2, busy2, ready0, error0, busy0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  multicycle_mem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) u_dut2 (
    .clock(clock), .reset(reset), .read_enable(re2), .write_enable(we2),
    .address(addr2), .write_data(wd2), .byte_mask(mask2),
    .read_data(rd2), .ready(ready2), .error(error2), .busy(busy2)
  );

  multicycle_mem_responder #(.ADDR_WIDTH(12), .LATENCY(0)) u_dut0 (
    .clock(clock), .reset(reset), .read_enable(re0), .write_enable(we0),
    .address(addr0), .write_data(wd0), .byte_mask(mask0),
    .read_data(rd0), .ready(ready0), .error(error0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; sel=1 drives the LATENCY=2 instance, sel=0 the LATENCY=0 one.
  task automatic txn(input bit sel, input logic re, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] mask, input int exp_lat,
                     input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int cycles;
    @(negedge clock);
    if (sel) begin
      re2 = re; we2 = we; addr2 = addr; wd2 = wd; mask2 = mask;
    end else begin
      re0 = re; we0 = we; addr0 = addr; wd0 = wd; mask0 = mask;
    end
    cycles = 0;
    while (cycles < 20) begin
      @(negedge clock);
      cycles++;
      if (cycles == 1) begin
        check({tag, " busy"}, 32'(sel ? busy2 : busy0), 32'd1);
        re2 = 1'b0; we2 = 1'b0; re0 = 1'b0; we0 = 1'b0;
      end
      if (sel ? ready2 : ready0) break;
    end
    check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, " error"}, 32'(sel ? error2 : error0), 32'(exp_err));
    check({tag, " read_data"}, sel ? rd2 : rd0, exp_rd);
    @(negedge clock);
    check({tag, " ready drops"}, 32'(sel ? ready2 : ready0), 32'd0);
    check({tag, " idle"}, 32'(sel ? busy2 : busy0), 32'd0);
  endtask

  initial begin
    int cycles;
    int pulses;
    repeat (2) @(negedge clock);
    check("reset ready", 32'(ready2), 32'd0);
    check("reset error", 32'(error2), 32'd0);
    check("reset busy", 32'(busy2), 32'd0);
    check("reset read_data", rd2, 32'd0);
    check("reset read_data l0", rd0, 32'd0);
    reset = 1'b0;

    // LATENCY=2: write/read, byte mask, illegal requests
    txn(1'b1, 1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 3, 1'b0, 32'h0, "wr1");
    txn(1'b1, 1'b1, 1'b0, 32'h010, 32'h0, 4'h0, 3, 1'b0, 32'hDEADBEEF, "rd1");
    txn(1'b1, 1'b0, 1'b1, 32'h010, 32'h11223344, 4'b0101, 3, 1'b0, 32'hDEADBEEF, "wrmask");
    txn(1'b1, 1'b1, 1'b0, 32'h010, 32'h0, 4'h0, 3, 1'b0, 32'hDE22BE44, "rdmask");
    txn(1'b1, 1'b1, 1'b0, 32'h013, 32'h0, 4'h0, 3, 1'b1, 32'hDE22BE44, "misalign");
    txn(1'b1, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 3, 1'b1, 32'hDE22BE44, "range");
    txn(1'b1, 1'b1, 1'b1, 32'h010, 32'h0, 4'hF, 3, 1'b1, 32'hDE22BE44, "both");
    txn(1'b1, 1'b1, 1'b0, 32'h010, 32'h0, 4'h0, 3, 1'b0, 32'hDE22BE44, "rdafter");

    // Ignored strobe during WAIT
    @(negedge clock);
    we2 = 1'b1; addr2 = 32'h030; wd2 = 32'hCAFEF00D; mask2 = 4'hF;
    @(negedge clock);
    cycles = 1;
    wd2 = 32'h12345678;
    while (cycles < 20) begin
      @(negedge clock);
      cycles++;
      if (cycles == 2) we2 = 1'b0;
      if (ready2) break;
    end
    check("ignore latency", 32'(cycles), 32'd3);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (ready2) pulses++;
    end
    check("ignore extra ready", 32'(pulses), 32'd0);
    txn(1'b1, 1'b1, 1'b0, 32'h030, 32'h0, 4'h0, 3, 1'b0, 32'hCAFEF00D, "rdignore");

    // LATENCY=0 instance
    txn(1'b0, 1'b0, 1'b1, 32'h040, 32'hA5A5A5A5, 4'hF, 1, 1'b0, 32'h0, "l0wr");
    txn(1'b0, 1'b1, 1'b0, 32'h040, 32'h0, 4'h0, 1, 1'b0, 32'hA5A5A5A5, "l0rd");
    @(negedge clock);
    re0 = 1'b1; addr0 = 32'h040;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("l0held ready %0d", i), 32'(ready0), 32'((i % 2) == 0));
    end
    re0 = 1'b0;
    repeat (2) @(negedge clock);

    // Reset during WAIT of a write
    txn(1'b1, 1'b0, 1'b1, 32'h020, 32'h0, 4'hF, 3, 1'b0, 32'hCAFEF00D, "wrzero");
    @(negedge clock);
    we2 = 1'b1; addr2 = 32'h020; wd2 = 32'hFFFFFFFF; mask2 = 4'hF;
    @(negedge clock);
    we2 = 1'b0;
    check("rst pre busy", 32'(busy2), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst ready", 32'(ready2), 32'd0);
    check("rst busy", 32'(busy2), 32'd0);
    check("rst read_data", rd2, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    txn(1'b1, 1'b1, 1'b0, 32'h020, 32'h0, 4'h0, 3, 1'b0, 32'h0, "rdrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
